// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multi-cycle MIPS control unit.
// Opcodes, functs, ALU codes, FSM states and select-field encodings.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BLTZ  = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_NOR = 6'b010001;
  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SRL = 6'b100001;
  localparam logic [5:0] ALU_SRA = 6'b100011;
  localparam logic [5:0] ALU_EQ  = 6'b110011;
  localparam logic [5:0] ALU_NEQ = 6'b110001;
  localparam logic [5:0] ALU_LT  = 6'b110101;
  localparam logic [5:0] ALU_LEZ = 6'b111101;
  localparam logic [5:0] ALU_LTZ = 6'b111011;
  localparam logic [5:0] ALU_GTZ = 6'b111111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_ALU_R,
    C_ALU_I,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JUMP,
    C_JUMP_REG,
    C_ILLEGAL
  } cls_e;

  localparam logic [2:0] PC_PLUS4  = 3'd0;
  localparam logic [2:0] PC_BRANCH = 3'd1;
  localparam logic [2:0] PC_JUMP   = 3'd2;
  localparam logic [2:0] PC_REG    = 3'd3;
  localparam logic [2:0] PC_ILLOP  = 3'd4;
  localparam logic [2:0] PC_XADR   = 3'd5;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;
  localparam logic [1:0] RD_K0 = 2'd3;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  localparam logic [1:0] CAUSE_IRQ    = 2'd0;
  localparam logic [1:0] CAUSE_ILLOP  = 2'd1;
  localparam logic [1:0] CAUSE_BUSERR = 2'd2;

  typedef struct packed {
    logic [5:0] alu_fun;
    logic       alu_src1;
    logic       alu_src2;
    logic       sign;
    logic       ext_op;
    logic       lu_op;
    logic       link;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
  } dec_t;

endpackage

// File: rtl/mips_decode.sv
// mips_decode: combinational instruction classifier.
// Produces the instruction class and its static control fields.
module mips_decode
  import mips_ctrl_pkg::*;
(
  input  logic [31:0] instruct,
  output cls_e        cls,
  output dec_t        ctrl
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_fields;

  assign op = instruct[31:26];
  assign fn = instruct[5:0];
  assign unused_fields = ^instruct[25:6];

  // Classify opcode/funct and set the static fields
  always_comb begin
    cls  = C_ILLEGAL;
    ctrl = '0;
    ctrl.sign   = 1'b1;
    ctrl.ext_op = 1'b1;
    unique case (op)
      OP_RTYPE: begin
        cls = C_ALU_R;
        ctrl.reg_dst = RD_RD;
        unique case (fn)
          FN_SLL: begin
            ctrl.alu_fun  = ALU_SLL;
            ctrl.alu_src1 = 1'b1;
          end
          FN_SRL: begin
            ctrl.alu_fun  = ALU_SRL;
            ctrl.alu_src1 = 1'b1;
          end
          FN_SRA: begin
            ctrl.alu_fun  = ALU_SRA;
            ctrl.alu_src1 = 1'b1;
          end
          FN_JR:   cls = C_JUMP_REG;
          FN_JALR: begin
            cls = C_JUMP_REG;
            ctrl.link       = 1'b1;
            ctrl.mem_to_reg = WB_PC;
          end
          FN_ADD:  ctrl.alu_fun = ALU_ADD;
          FN_ADDU: ctrl.sign    = 1'b0;
          FN_SUB:  ctrl.alu_fun = ALU_SUB;
          FN_SUBU: begin
            ctrl.alu_fun = ALU_SUB;
            ctrl.sign    = 1'b0;
          end
          FN_AND:  ctrl.alu_fun = ALU_AND;
          FN_OR:   ctrl.alu_fun = ALU_OR;
          FN_XOR:  ctrl.alu_fun = ALU_XOR;
          FN_NOR:  ctrl.alu_fun = ALU_NOR;
          FN_SLT:  ctrl.alu_fun = ALU_LT;
          FN_SLTU: begin
            ctrl.alu_fun = ALU_LT;
            ctrl.sign    = 1'b0;
          end
          default: cls = C_ILLEGAL;
        endcase
      end
      OP_BLTZ: begin
        cls = C_BRANCH;
        ctrl.alu_fun = ALU_LTZ;
      end
      OP_J: cls = C_JUMP;
      OP_JAL: begin
        cls = C_JUMP;
        ctrl.link       = 1'b1;
        ctrl.reg_dst    = RD_RA;
        ctrl.mem_to_reg = WB_PC;
      end
      OP_BEQ: begin
        cls = C_BRANCH;
        ctrl.alu_fun = ALU_EQ;
      end
      OP_BNE: begin
        cls = C_BRANCH;
        ctrl.alu_fun = ALU_NEQ;
      end
      OP_BLEZ: begin
        cls = C_BRANCH;
        ctrl.alu_fun = ALU_LEZ;
      end
      OP_BGTZ: begin
        cls = C_BRANCH;
        ctrl.alu_fun = ALU_GTZ;
      end
      OP_ADDI, OP_ADDIU: begin
        cls = C_ALU_I;
        ctrl.alu_src2 = 1'b1;
      end
      OP_SLTI: begin
        cls = C_ALU_I;
        ctrl.alu_fun  = ALU_LT;
        ctrl.alu_src2 = 1'b1;
      end
      OP_SLTIU: begin
        cls = C_ALU_I;
        ctrl.alu_fun  = ALU_LT;
        ctrl.alu_src2 = 1'b1;
        ctrl.sign     = 1'b0;
      end
      OP_ANDI: begin
        cls = C_ALU_I;
        ctrl.alu_fun  = ALU_AND;
        ctrl.alu_src2 = 1'b1;
        ctrl.ext_op   = 1'b0;
      end
      OP_LUI: begin
        cls = C_ALU_I;
        ctrl.alu_src2 = 1'b1;
        ctrl.lu_op    = 1'b1;
      end
      OP_LW: begin
        cls = C_LOAD;
        ctrl.alu_src2   = 1'b1;
        ctrl.mem_to_reg = WB_MEM;
      end
      OP_SW: begin
        cls = C_STORE;
        ctrl.alu_src2 = 1'b1;
      end
      default: cls = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle MIPS control FSM with IRQ,
// illegal-opcode and memory-timeout traps.
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter  int IRQ_N       = 1,
  parameter  int MEM_TIMEOUT = 16,
  localparam int IW = (IRQ_N > 1) ? $clog2(IRQ_N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruct,
  input  logic [IRQ_N-1:0] irq,
  input  logic             pc_high,
  input  logic             mem_ready,
  input  logic             cmp_true,
  output logic             pc_wr,
  output logic             ir_wr,
  output logic             epc_wr,
  output logic [2:0]       pc_src,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             reg_wr,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src1,
  output logic             alu_src2,
  output logic [5:0]       alu_fun,
  output logic             sign,
  output logic             ext_op,
  output logic             lu_op,
  output logic [1:0]       cause,
  output logic [IW-1:0]    irq_id,
  output logic [2:0]       state
);

  localparam int CW =
    (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_MAX = CW'(MEM_TIMEOUT);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cause_q, cause_d;
  logic [IW-1:0] irq_id_q, irq_id_d;

  cls_e          cls;
  dec_t          dc;
  logic          irq_hit;
  logic [IW-1:0] irq_idx;
  logic          waiting;
  logic          expired;

  mips_decode u_dec (
    .instruct (instruct),
    .cls      (cls),
    .ctrl     (dc)
  );

  assign waiting = (state_q == S_FETCH || state_q == S_MEM)
                   && !mem_ready;
  assign expired = (MEM_TIMEOUT != 0) && waiting
                   && (cnt_q == TO_MAX);

  assign cause  = cause_q;
  assign irq_id = irq_id_q;
  assign state  = state_q;

  // Lowest-index pending IRQ wins
  always_comb begin
    irq_hit = 1'b0;
    irq_idx = '0;
    for (int i = IRQ_N - 1; i >= 0; i--) begin
      if (irq[i]) begin
        irq_hit = 1'b1;
        irq_idx = IW'(i);
      end
    end
  end

  // State, wait counter and trap bookkeeping registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      cnt_q    <= '0;
      cause_q  <= CAUSE_IRQ;
      irq_id_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
      irq_id_q <= irq_id_d;
    end
  end

  // Next state, with IRQ diversion on the way back to FETCH
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    irq_id_d = irq_id_q;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_BUSERR;
        end
      end
      S_DECODE: begin
        if (cls == C_ILLEGAL) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLOP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (cls)
          C_ALU_R, C_ALU_I: state_d = S_WB;
          C_LOAD, C_STORE:  state_d = S_MEM;
          default:          state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = (cls == C_LOAD) ? S_WB : S_FETCH;
        end else if (expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_BUSERR;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
    if (state_d == S_FETCH && irq_hit && !pc_high
        && state_q inside {S_EXEC, S_MEM, S_WB}) begin
      state_d  = S_TRAP;
      cause_d  = CAUSE_IRQ;
      irq_id_d = irq_idx;
    end
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (waiting && MEM_TIMEOUT != 0) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Per-state control outputs; all quiet while in reset
  always_comb begin
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    epc_wr     = 1'b0;
    pc_src     = PC_PLUS4;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = RD_RT;
    mem_to_reg = WB_ALU;
    alu_src1   = 1'b0;
    alu_src2   = 1'b0;
    alu_fun    = ALU_ADD;
    sign       = 1'b0;
    ext_op     = 1'b0;
    lu_op      = 1'b0;
    if (!reset) begin
      unique case (state_q)
        S_FETCH: begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            ir_wr  = 1'b1;
            pc_wr  = 1'b1;
            pc_src = PC_PLUS4;
          end
        end
        S_EXEC: begin
          alu_fun  = dc.alu_fun;
          alu_src1 = dc.alu_src1;
          alu_src2 = dc.alu_src2;
          sign     = dc.sign;
          ext_op   = dc.ext_op;
          lu_op    = dc.lu_op;
          if (cls == C_BRANCH) begin
            pc_wr  = cmp_true;
            pc_src = PC_BRANCH;
          end
          if (cls == C_JUMP) begin
            pc_wr  = 1'b1;
            pc_src = PC_JUMP;
          end
          if (cls == C_JUMP_REG) begin
            pc_wr  = 1'b1;
            pc_src = PC_REG;
          end
          if (dc.link) begin
            reg_wr     = 1'b1;
            reg_dst    = dc.reg_dst;
            mem_to_reg = dc.mem_to_reg;
          end
        end
        S_MEM: begin
          mem_rd = (cls == C_LOAD);
          mem_wr = (cls == C_STORE);
        end
        S_WB: begin
          reg_wr     = 1'b1;
          reg_dst    = dc.reg_dst;
          mem_to_reg = dc.mem_to_reg;
        end
        S_TRAP: begin
          epc_wr = 1'b1;
          pc_wr  = 1'b1;
          pc_src = (cause_q == CAUSE_ILLOP) ? PC_ILLOP
                                            : PC_XADR;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: directed and random instruction sequences
// checked against a per-instruction state-sequence model.
module tb_mips_mc_ctrl;
  import mips_ctrl_pkg::*;

  localparam int TO = 3;
  localparam int K_ALU = 0;
  localparam int K_LD  = 1;
  localparam int K_ST  = 2;
  localparam int K_BR  = 3;
  localparam int K_J   = 4;
  localparam int K_JR  = 5;
  localparam int K_ILL = 6;

  localparam logic [5:0] GOOD_OP [14] = '{
    6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
    6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f, 6'h23};
  localparam logic [5:0] GOOD_FN [15] = '{
    6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h21,
    6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
  localparam logic [5:0] BAD_OP [5] = '{
    6'h0d, 6'h0e, 6'h10, 6'h3f, 6'h20};
  localparam logic [5:0] BAD_FN [4] = '{
    6'h01, 6'h28, 6'h3f, 6'h0c};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruct = '0;
  logic [3:0]  irq = '0;
  logic        pc_high = 1'b0;
  logic        mem_ready = 1'b0;
  logic        cmp_true = 1'b0;
  logic        pc_wr, ir_wr, epc_wr, mem_rd, mem_wr, reg_wr;
  logic [2:0]  pc_src;
  logic [1:0]  reg_dst, mem_to_reg, cause, irq_id;
  logic        alu_src1, alu_src2, sign, ext_op, lu_op;
  logic [5:0]  alu_fun;
  logic [2:0]  state;
  logic [23:0] obs;

  int          n_run = 0;
  int          n_fail = 0;
  logic [1:0]  exp_irq_id = '0;

  typedef struct {
    int         cls;
    logic [5:0] fun;
    logic       s1, s2, sg, ex, lu, lnk;
    logic [1:0] rd, m2r;
  } ref_t;

  mips_mc_ctrl #(.IRQ_N(4), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .instruct(instruct),
    .irq(irq), .pc_high(pc_high), .mem_ready(mem_ready),
    .cmp_true(cmp_true), .pc_wr(pc_wr), .ir_wr(ir_wr),
    .epc_wr(epc_wr), .pc_src(pc_src), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .reg_wr(reg_wr), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src1(alu_src1),
    .alu_src2(alu_src2), .alu_fun(alu_fun), .sign(sign),
    .ext_op(ext_op), .lu_op(lu_op), .cause(cause),
    .irq_id(irq_id), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {mem_rd, mem_wr, ir_wr, pc_wr, epc_wr, reg_wr,
                pc_src, reg_dst, mem_to_reg, alu_src1, alu_src2,
                alu_fun, sign, ext_op, lu_op};

  function automatic ref_t ref_dec(input logic [31:0] ins);
    ref_t r;
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    r.cls = K_ILL; r.fun = 6'b000000;
    r.s1 = 0; r.s2 = 0; r.sg = 1; r.ex = 1; r.lu = 0;
    r.lnk = 0; r.rd = 0; r.m2r = 0;
    case (op)
      6'h00: begin
        r.cls = K_ALU; r.rd = 1;
        case (fn)
          6'h00: begin r.fun = 6'b100000; r.s1 = 1; end
          6'h02: begin r.fun = 6'b100001; r.s1 = 1; end
          6'h03: begin r.fun = 6'b100011; r.s1 = 1; end
          6'h08: r.cls = K_JR;
          6'h09: begin r.cls = K_JR; r.lnk = 1; r.m2r = 2; end
          6'h20: r.fun = 6'b000000;
          6'h21: r.sg = 0;
          6'h22: r.fun = 6'b000001;
          6'h23: begin r.fun = 6'b000001; r.sg = 0; end
          6'h24: r.fun = 6'b011000;
          6'h25: r.fun = 6'b011110;
          6'h26: r.fun = 6'b010110;
          6'h27: r.fun = 6'b010001;
          6'h2a: r.fun = 6'b110101;
          6'h2b: begin r.fun = 6'b110101; r.sg = 0; end
          default: r.cls = K_ILL;
        endcase
      end
      6'h01: begin r.cls = K_BR; r.fun = 6'b111011; end
      6'h02: r.cls = K_J;
      6'h03: begin r.cls = K_J; r.lnk = 1; r.rd = 2; r.m2r = 2; end
      6'h04: begin r.cls = K_BR; r.fun = 6'b110011; end
      6'h05: begin r.cls = K_BR; r.fun = 6'b110001; end
      6'h06: begin r.cls = K_BR; r.fun = 6'b111101; end
      6'h07: begin r.cls = K_BR; r.fun = 6'b111111; end
      6'h08, 6'h09: begin r.cls = K_ALU; r.s2 = 1; end
      6'h0a: begin r.cls = K_ALU; r.s2 = 1; r.fun = 6'b110101; end
      6'h0b: begin
        r.cls = K_ALU; r.s2 = 1; r.fun = 6'b110101; r.sg = 0;
      end
      6'h0c: begin
        r.cls = K_ALU; r.s2 = 1; r.fun = 6'b011000; r.ex = 0;
      end
      6'h0f: begin r.cls = K_ALU; r.s2 = 1; r.lu = 1; end
      6'h23: begin r.cls = K_LD; r.s2 = 1; r.m2r = 1; end
      6'h2b: begin r.cls = K_ST; r.s2 = 1; end
      default: r.cls = K_ILL;
    endcase
    return r;
  endfunction

  task automatic run_instr(input string nm, input logic [31:0] ins,
                           input int fw, input int mw,
                           input logic cmp, input logic [3:0] iq,
                           input logic ph);
    ref_t r;
    state_e q[$];
    bit rq[$];
    int tcause;
    bit done;
    logic [23:0] e;
    logic mrd, mwr, irw, pcw, epc, rw, s1, s2, sg, ex, lu;
    logic [2:0] ps;
    logic [1:0] rd, m2r;
    logic [5:0] fn;
    r = ref_dec(ins);
    done = 0;
    tcause = 0;
    for (int i = 0; i <= fw && i <= TO; i++) begin
      q.push_back(S_FETCH);
      rq.push_back(i == fw);
    end
    if (fw > TO) begin
      q.push_back(S_TRAP); rq.push_back(1'($urandom));
      tcause = 2; done = 1;
    end
    if (!done) begin
      q.push_back(S_DECODE); rq.push_back(1'($urandom));
      if (r.cls == K_ILL) begin
        q.push_back(S_TRAP); rq.push_back(1'($urandom));
        tcause = 1; done = 1;
      end
    end
    if (!done) begin
      q.push_back(S_EXEC); rq.push_back(1'($urandom));
      if (r.cls == K_LD || r.cls == K_ST) begin
        for (int i = 0; i <= mw && i <= TO; i++) begin
          q.push_back(S_MEM);
          rq.push_back(i == mw);
        end
        if (mw > TO) begin
          q.push_back(S_TRAP); rq.push_back(1'($urandom));
          tcause = 2; done = 1;
        end else if (r.cls == K_LD) begin
          q.push_back(S_WB); rq.push_back(1'($urandom));
        end
      end else if (r.cls == K_ALU) begin
        q.push_back(S_WB); rq.push_back(1'($urandom));
      end
    end
    if (!done && iq != 0 && !ph) begin
      q.push_back(S_TRAP); rq.push_back(1'($urandom));
      tcause = 0;
      for (int i = 3; i >= 0; i--)
        if (iq[i]) exp_irq_id = 2'(i);
    end
    instruct = ins;
    cmp_true = cmp;
    irq = iq;
    pc_high = ph;
    foreach (q[k]) begin
      mem_ready = rq[k];
      #1;
      {mrd, mwr, irw, pcw, epc, rw, s1, s2, sg, ex, lu} = '0;
      ps = 0; rd = 0; m2r = 0; fn = 0;
      case (q[k])
        S_FETCH: begin mrd = 1; irw = rq[k]; pcw = rq[k]; end
        S_EXEC: begin
          fn = r.fun; s1 = r.s1; s2 = r.s2;
          sg = r.sg; ex = r.ex; lu = r.lu;
          if (r.cls == K_BR) begin pcw = cmp; ps = 1; end
          if (r.cls == K_J)  begin pcw = 1; ps = 2; end
          if (r.cls == K_JR) begin pcw = 1; ps = 3; end
          if (r.lnk) begin rw = 1; rd = r.rd; m2r = r.m2r; end
        end
        S_MEM: begin
          mrd = (r.cls == K_LD);
          mwr = (r.cls == K_ST);
        end
        S_WB: begin rw = 1; rd = r.rd; m2r = r.m2r; end
        S_TRAP: begin
          epc = 1; pcw = 1;
          ps = (tcause == 1) ? 3'd4 : 3'd5;
        end
        default: ;
      endcase
      e = {mrd, mwr, irw, pcw, epc, rw, ps, rd, m2r,
           s1, s2, fn, sg, ex, lu};
      n_run++;
      if (state !== q[k]) begin
        n_fail++;
        $display("FAIL %s c%0d state: got %0d want %0d",
                 nm, k, state, q[k]);
      end
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s c%0d outputs: got %h want %h",
                 nm, k, obs, e);
      end
      if (q[k] == S_TRAP) begin
        n_run++;
        if (cause !== 2'(tcause)) begin
          n_fail++;
          $display("FAIL %s c%0d cause: got %0d want %0d",
                   nm, k, cause, tcause);
        end
        n_run++;
        if (irq_id !== exp_irq_id) begin
          n_fail++;
          $display("FAIL %s c%0d irq_id: got %0d want %0d",
                   nm, k, irq_id, exp_irq_id);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rand_ins();
    logic [31:0] x;
    int s;
    x = $urandom;
    s = $urandom_range(0, 9);
    if (s == 0) begin
      x[31:26] = BAD_OP[$urandom_range(0, 4)];
    end else if (s == 1) begin
      x[31:26] = 6'h00;
      x[5:0] = BAD_FN[$urandom_range(0, 3)];
    end else if (s < 5) begin
      x[31:26] = 6'h00;
      x[5:0] = GOOD_FN[$urandom_range(0, 14)];
    end else if (s == 5) begin
      x[31:26] = 6'h2b;
    end else begin
      x[31:26] = GOOD_OP[$urandom_range(0, 13)];
    end
    return x;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_run++;
    if (obs !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_hold outputs: got %h want 000000", obs);
    end
    reset = 1'b0;
    mem_ready = 1'b0;
    exp_irq_id = '0;
    #1;
    n_run++;
    if (state !== S_FETCH) begin
      n_fail++;
      $display("FAIL reset state: got %0d want 0", state);
    end
    n_run++;
    if (obs !== 24'h800000) begin
      n_fail++;
      $display("FAIL reset outputs: got %h want 800000", obs);
    end
    n_run++;
    if (cause !== 2'd0 || irq_id !== 2'd0) begin
      n_fail++;
      $display("FAIL reset cause/irq_id: got %0d/%0d want 0/0",
               cause, irq_id);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    run_instr("add", 32'h00430820, 0, 0, 0, 4'h0, 0);
    run_instr("add_fwait", 32'h00430820, 2, 0, 0, 4'h0, 0);
  endtask

  task automatic test_lw_wait();
    run_instr("lw_wait2", 32'h8c220004, 0, 2, 0, 4'h0, 0);
    run_instr("sw_wait1", 32'hac220004, 0, 1, 0, 4'h0, 0);
  endtask

  task automatic test_branch();
    run_instr("beq_taken", 32'h10220003, 0, 0, 1, 4'h0, 0);
    run_instr("beq_not", 32'h10220003, 0, 0, 0, 4'h0, 0);
    run_instr("bltz", 32'h04400002, 0, 0, 1, 4'h0, 0);
  endtask

  task automatic test_illegal();
    run_instr("illop", 32'hfc000000, 0, 0, 0, 4'h0, 0);
    run_instr("bad_fn", 32'h00430801, 0, 0, 0, 4'h0, 0);
  endtask

  task automatic test_irq();
    run_instr("irq_wb", 32'h00430820, 0, 0, 0, 4'b1010, 0);
    run_instr("irq_kmode", 32'h00430820, 0, 0, 0, 4'b1010, 1);
    run_instr("irq_sw", 32'hac220004, 0, 0, 0, 4'b1000, 0);
  endtask

  task automatic test_timeout();
    run_instr("fetch_to", 32'h00430820, 4, 0, 0, 4'h0, 0);
    run_instr("fetch_edge", 32'h00430820, 3, 0, 0, 4'h0, 0);
    run_instr("lw_to", 32'h8c220004, 0, 4, 0, 4'h0, 0);
    run_instr("sw_edge", 32'hac220004, 0, 3, 0, 4'h0, 0);
  endtask

  task automatic test_jumps();
    run_instr("j", 32'h08000010, 0, 0, 0, 4'h0, 0);
    run_instr("jal", 32'h0c000010, 0, 0, 0, 4'b0100, 0);
    run_instr("jr", 32'h03e00008, 1, 0, 0, 4'h0, 0);
    run_instr("jalr", 32'h03e0f809, 0, 0, 0, 4'h0, 0);
  endtask

  task automatic test_reset_mid_request();
    instruct = 32'hac220004;
    irq = '0;
    pc_high = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #1;
    n_run++;
    if (mem_wr !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_req mem_wr: got %b want 1", mem_wr);
    end
    reset = 1'b1;
    #1;
    n_run++;
    if (obs !== 24'h0) begin
      n_fail++;
      $display("FAIL mid_req drop: got %h want 000000", obs);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_irq_id = '0;
    #1;
    n_run++;
    if (state !== S_FETCH) begin
      n_fail++;
      $display("FAIL mid_req state: got %0d want 0", state);
    end
  endtask

  task automatic test_random();
    int fw;
    int mw;
    logic [3:0] iq;
    for (int n = 0; n < 300; n++) begin
      fw = ($urandom_range(0, 7) == 0) ? 4 : $urandom_range(0, 3);
      mw = ($urandom_range(0, 7) == 0) ? 4 : $urandom_range(0, 3);
      iq = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      run_instr("random", rand_ins(), fw, mw, 1'($urandom),
                iq, 1'($urandom));
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_illegal();
    test_irq();
    test_timeout();
    test_jumps();
    test_reset_mid_request();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
